// File: rtl/force_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : force_pkg                                                   |
// | Purpose    : Shared definitions for the pin force sequencer: state       |
// |              encoding, default parameter values, the released EN_BAR     |
// |              level and a small width helper.                             |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package force_pkg;

  // Sequencer states and their 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_DRIVE   = 2'd2,
    ST_RELEASE = 2'd3
  } force_state_e;

  localparam int C_STATE_W = 2;

  // Plain vector constants of the same encoding, used for the state register.
  localparam logic [C_STATE_W-1:0] S_IDLE    = ST_IDLE;
  localparam logic [C_STATE_W-1:0] S_SETUP   = ST_SETUP;
  localparam logic [C_STATE_W-1:0] S_DRIVE   = ST_DRIVE;
  localparam logic [C_STATE_W-1:0] S_RELEASE = ST_RELEASE;

  // Default parameter values.
  localparam int C_DEF_WIDTH       = 8;
  localparam int C_DEF_HOLD_W      = 16;
  localparam int C_DEF_TURN_CYCLES = 2;

  // EN_BAR level of a released driver; replicated to the bank width.
  localparam logic C_RELEASED_BIT = 1'b1;

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/force_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : force_cnt                                                   |
// | Purpose    : Loadable down-counter with a zero flag. Shared by all timed |
// |              phases of the force sequencer; stops at zero (no wrap).     |
// | Ports      : CLK      - clock, rising edge                              |
// |              RST      - asynchronous active-high reset (count -> 0)     |
// |              LOAD     - load LOAD_VAL this edge (priority over count)   |
// |              LOAD_VAL - value to load                                   |
// |              ZERO     - count currently equals zero                     |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module force_cnt #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_VAL,
  output logic         ZERO
);

  logic [W-1:0] r_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else if (LOAD) begin
      r_count <= LOAD_VAL;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign ZERO = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pin_force_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : pin_force_ctrl                                              |
// | Purpose    : Sequencer for a bank of tristate pin drivers. A START in    |
// |              IDLE captures pattern/mask/duration, presents the pattern   |
// |              with drivers released (SETUP), enables the masked drivers   |
// |              for HOLD cycles (DRIVE), releases them for a turnaround     |
// |              (RELEASE) and pulses DONE on return to IDLE.                |
// | Ports      : CLK, RST (async, active-high)                               |
// |              START, ABORT            - control                          |
// |              DATA, MASK [WIDTH], HOLD [HOLD_W] - captured with START    |
// |              REPEAT [8]              - only with FORCE_REPEAT_EN        |
// |              PIN_I, PIN_EN_BAR [WIDTH] - to TRIREG I / EN_BAR           |
// |              BUSY, DONE              - status (registered)              |
// | Options    : FORCE_REPEAT_EN - adds REPEAT; the pattern is forced        |
// |              REPEAT+1 times per START with a single final DONE.          |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module pin_force_ctrl
  import force_pkg::*;
#(
  parameter int WIDTH       = C_DEF_WIDTH,
  parameter int HOLD_W      = C_DEF_HOLD_W,
  parameter int TURN_CYCLES = C_DEF_TURN_CYCLES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [WIDTH-1:0]  DATA,
  input  logic [WIDTH-1:0]  MASK,
  input  logic [HOLD_W-1:0] HOLD,
`ifdef FORCE_REPEAT_EN
  input  logic [7:0]        REPEAT,
`endif
  output logic [WIDTH-1:0]  PIN_I,
  output logic [WIDTH-1:0]  PIN_EN_BAR,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CNT_W = f_max(HOLD_W, $clog2(TURN_CYCLES + 1));
  localparam logic [WIDTH-1:0] C_RELEASED = {WIDTH{C_RELEASED_BIT}};

  logic [C_STATE_W-1:0] r_state;
  logic [C_STATE_W-1:0] w_next;
  logic [WIDTH-1:0]     r_mask;
  logic [HOLD_W-1:0]    r_hold;
  logic [HOLD_W-1:0]    w_hold_m1;
  logic [CNT_W-1:0]     w_load_val;
  logic                 w_load;
  logic                 w_zero;
  logic                 w_start;
  logic                 w_abort;
  logic                 w_more;

  assign w_start   = (r_state == S_IDLE) && START;
  assign w_abort   = ABORT && ((r_state == S_SETUP) || (r_state == S_DRIVE));
  // Only used on the SETUP->DRIVE transition, where r_hold is known nonzero,
  // so HOLD = all-ones loads all-ones minus one and never wraps.
  assign w_hold_m1 = r_hold - HOLD_W'(1);

`ifdef FORCE_REPEAT_EN
  logic [7:0] r_rep;

  assign w_more = (r_rep != 8'd0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rep <= 8'd0;
    end else if (w_start) begin
      r_rep <= REPEAT;
    end else if (w_abort) begin
      r_rep <= 8'd0;
    end else if ((r_state == S_RELEASE) && w_zero && w_more) begin
      r_rep <= r_rep - 8'd1;
    end
  end
`else
  assign w_more = 1'b0;
`endif

  // Next-state logic. Each timed phase lasts (loaded value + 1) cycles and
  // leaves when the shared counter reads zero.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (START) w_next = S_SETUP;
      end
      S_SETUP: begin
        if (ABORT) begin
          w_next = S_RELEASE;
        end else if (w_zero) begin
          w_next = (r_hold == '0) ? S_RELEASE : S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (ABORT || w_zero) w_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (w_zero) w_next = w_more ? S_SETUP : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Every state change is a state entry and reloads the counter.
  assign w_load = (w_next != r_state);

  always_comb begin
    w_load_val = '0;
    case (w_next)
      S_SETUP, S_RELEASE: w_load_val = CNT_W'(TURN_CYCLES - 1);
      S_DRIVE:            w_load_val = CNT_W'(w_hold_m1);
      default:            w_load_val = '0;
    endcase
  end

  force_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .LOAD     (w_load),
    .LOAD_VAL (w_load_val),
    .ZERO     (w_zero)
  );

  // PIN_I doubles as the captured pattern register; it only changes on the
  // IDLE->SETUP edge, when every driver is already released.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_mask     <= '0;
      r_hold     <= '0;
      PIN_I      <= '0;
      PIN_EN_BAR <= C_RELEASED;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_mask <= MASK;
        r_hold <= HOLD;
        PIN_I  <= DATA;
      end
      PIN_EN_BAR <= (w_next == S_DRIVE) ? ~r_mask : C_RELEASED;
      BUSY       <= (w_next != S_IDLE);
      DONE       <= (r_state != S_IDLE) && (w_next == S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: doc/pin_force_ctrl.md
# pin_force_ctrl

Sequencer for a bank of tristate pin drivers used to force signals onto DUT pins. On each START it captures a pattern and pin mask, presents the pattern while the drivers stay released, and then enables the masked drivers for a programmed number of cycles. It then releases all drivers and waits a turnaround interval before reporting completion. It sits between the tester command logic and the per-pin TRIREG instances, driving their `I` and `EN_BAR` inputs.

## Interface
- `WIDTH`, 8: number of forced pins.
- `HOLD_W`, 16: width of the drive-duration count.
- `TURN_CYCLES`, 2: setup/release turnaround length in cycles; legal range ≥1.
- `CLK` input 1: single clock; all logic on its rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `START` input 1: begin a force sequence; sampled only in IDLE.
- `ABORT` input 1: terminate the sequence early; synchronous.
- `DATA` input WIDTH: pattern to force; captured with START.
- `MASK` input WIDTH: 1 = pin is driven; captured with START.
- `HOLD` input HOLD_W: number of DRIVE cycles; captured with START.
- `PIN_I` output WIDTH: to the TRIREG `I` inputs.
- `PIN_EN_BAR` output WIDTH: to the TRIREG `EN_BAR` inputs; 1 = released.
- `BUSY` output 1: high in every non-IDLE state.
- `DONE` output 1: one-cycle pulse on the return to IDLE.

## Operation
- Reset values: `PIN_EN_BAR` all ones, `PIN_I` 0, `BUSY` 0, `DONE` 0, state IDLE, all counters 0.
  - Reset releases all pins asynchronously, including in the middle of DRIVE.
- States: IDLE → SETUP → DRIVE → RELEASE → IDLE.
- **IDLE**
  - `START`=1 captures DATA, MASK and HOLD into registers.
  - `PIN_I` takes the captured DATA on the same edge.
  - Next state is SETUP.
- **SETUP**
  - `PIN_EN_BAR` stays all ones.
  - Lasts TURN_CYCLES cycles.
  - Exits to DRIVE, or directly to RELEASE if the captured HOLD = 0. With HOLD = 0 no pin is ever enabled.
- **DRIVE**
  - `PIN_EN_BAR` = ~captured MASK.
  - Lasts exactly HOLD cycles, then goes to RELEASE.
- **RELEASE**
  - `PIN_EN_BAR` all ones.
  - Lasts TURN_CYCLES cycles.
  - `PIN_I` holds its value until IDLE.
  - Exits to IDLE and asserts DONE.
- **ABORT**
  - In SETUP or DRIVE: next state is RELEASE with a full turnaround, and all pins are released on that edge.
  - Ignored in IDLE and RELEASE.
  - ABORT and START in the same IDLE cycle: START wins.
- START outside IDLE is ignored; there is no queueing.
- Live DATA, MASK and HOLD are don't-care after capture.
- MASK = 0 runs the full timing and enables no pin.
- The counter is HOLD_W bits wide. HOLD = 2^HOLD_W−1 is legal and must not wrap.

## Timing
- With START accepted at edge k:
  - SETUP covers cycles k+1 … k+TURN_CYCLES.
  - DRIVE covers k+TURN_CYCLES+1 … k+TURN_CYCLES+HOLD.
  - RELEASE covers the next TURN_CYCLES cycles.
  - DONE is high in the first IDLE cycle, k+2·TURN_CYCLES+HOLD+1.
- A new START is accepted in the same cycle DONE is high.
- All outputs are registered, with no combinational path from inputs to outputs.
- `PIN_I` changes only on entry to SETUP, never while any pin is enabled.

## Configuration
- `FORCE_REPEAT_EN` defined:
  - Adds input `REPEAT` (8 bits), captured with START.
  - After RELEASE, if the remaining repeats are nonzero, the block re-enters SETUP and decrements the count; otherwise it goes to IDLE.
  - The pattern is forced REPEAT+1 times in total.
  - DONE pulses only once, at final completion.
  - ABORT cancels all remaining repeats.
- Not defined: no REPEAT port; a single pass per START.

## Structure
- Package `force_pkg` holds:
  - the state enum (IDLE, SETUP, DRIVE, RELEASE) and its 2-bit encoding;
  - the default-parameter constants;
  - the released constant (all-ones EN_BAR).
- One sub-module, `force_cnt`: a loadable down-counter of width max(HOLD_W, clog2(TURN_CYCLES+1)), with a `ZERO` flag. It is shared by SETUP, DRIVE and RELEASE and loaded on every state entry.

## Test plan
- **Basic pass:** TURN_CYCLES=2, DATA=0xA5, MASK=0xFF, HOLD=4, START at edge 0 → `PIN_EN_BAR`=0x00 exactly during cycles 3–6, `PIN_I`=0xA5 from cycle 1, DONE in cycle 9.
- **Zero hold:** HOLD=0, MASK=0xFF → `PIN_EN_BAR` stays 0xFF throughout; DONE in cycle 5.
- **Abort:** HOLD=100, ABORT in the 3rd DRIVE cycle → all pins released on the next edge; DONE exactly TURN_CYCLES+1 cycles after ABORT.
- **Reset mid-DRIVE:** assert RST asynchronously → `PIN_EN_BAR`=0xFF and BUSY=0 before the next clock edge; no DONE pulse.
- **Ignored START / partial mask:** START pulsed while BUSY → no restart, and timing unchanged. With MASK=0x0F → only `PIN_EN_BAR`[3:0]=0 during DRIVE, and bits [7:4] stay 1.
- **With `FORCE_REPEAT_EN`:** REPEAT=2, HOLD=3 → three DRIVE windows of 3 cycles, each separated by 2·TURN_CYCLES released cycles, and a single DONE pulse.
